bech_out_monitor: RTL
=====================

# bech_out_monitor

Downstream checker for the 18-input / 39-output benchmark control FSM. It samples that FSM's 39-bit output word once per enabled cycle and tracks the expected output sequence of each transaction. It reports completed transactions with their length and count, and flags sequence violations, including entries into the A-branch that did not come from idle. The intended use is as a runtime detector for tampered next-state paths.

## Interface
Parameters:
- MAX_BODY, 16, maximum enabled cycles allowed in BODY before a timeout; range 2..255.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  clock; all registers update on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sample enable; when low, all state, counters and outputs hold, except the pulses, which drop to 0.
- y_vec  in  39  upstream outputs; bit i carries y(i+1). The word is stable at the rising edge of clk because upstream updates on the falling edge.
- txn_done  out  1  one-cycle pulse when a transaction completes legally.
- txn_len  out  8  length of the last completed transaction; valid while txn_done is high, held otherwise.
- txn_cnt  out  CNT_W  number of legal completions; wraps modulo 2^CNT_W.
- err  out  1  one-cycle pulse on a violation.
- err_code  out  3  code of the most recent violation; held between violations.
- err_sticky  out  1  set by any err; cleared only by rst.

## Operation
"Word W exactly" means y_vec equals the bits named in W and every other bit is 0.

Monitor FSM, evaluated on enabled cycles only:
- IDLE:
  - y_vec == 0: stay.
  - {y35,y36} exactly: go to A1.
  - {y1} exactly: go to B1.
  - {y37,y38} exactly: err code 5 (ENTRY_NOT_FROM_IDLE), stay.
  - Any other nonzero word: err code 1 (UNEXP_START), stay.
- A1: {y37,y38} exactly goes to A2. Anything else: err code 2 (SEQ_MISMATCH), go to IDLE.
- A2: {y3,y28,y34} exactly completes the transaction (txn_done), go to IDLE. Anything else: err code 2, go to IDLE.
- B1: {y2,y3} exactly goes to B2. Anything else: err code 2, go to IDLE.
- B2: {y39} exactly goes to BODY. Anything else: err code 2, go to IDLE.
- BODY:
  - Any of y1, y35, y36, y37, y38 set: err code 3 (ILLEGAL_IN_BODY), go to IDLE. This takes priority over y34.
  - Otherwise y34 set: complete (txn_done), go to IDLE.
  - Otherwise, when the body counter reaches MAX_BODY: err code 4 (BODY_TIMEOUT), go to IDLE.

Error codes: 0 none (reset value), 1 through 5 as defined above, 6 and 7 reserved.

Counters and output rules:
- len counter:
  - Loads 1 on the start word.
  - Increments on each enabled cycle of the transaction, including the end word.
  - Saturates at 255.
- body counter: counts enabled BODY cycles only and clears on leaving BODY.
- A violating transaction does not update txn_cnt or txn_len.
- err and txn_done are never high in the same cycle.
- After an error, the monitor returns to IDLE without re-evaluating the offending word as a start word.

## Timing
- Decisions are registered: txn_done, err and err_code change in the cycle after the sampling edge of the deciding word.
- Latency from the end word to txn_done is 1 cycle. Path A completes in 3 sampled words.
- Reset values: FSM = IDLE, all counters 0, txn_done = 0, txn_len = 0, txn_cnt = 0, err = 0, err_code = 0, err_sticky = 0.
- rst asserted mid-transaction:
  - Immediately forces all reset values.
  - Does not produce an err or txn_done pulse.
  - Sampling resumes on the first enabled edge after deassertion.
- en low for any number of cycles mid-transaction: the transaction resumes unchanged, and idle cycles are not counted in length or timeout.

## Structure
- Shared package bech_mon_pkg contains:
  - the monitor state enumeration;
  - the err_code constants;
  - the expected-word masks W_A_START, W_A_MID, W_A_END, W_B_START, W_B_MID, W_B_BODY and W_ILLEGAL_BODY as 39-bit constants.
- One natural sub-module, bech_word_match: combinational; takes y_vec and produces one-hot "exact match" flags for each mask plus a body-illegal flag. The monitor FSM and counters stay in the top level.

## Test plan
- Path A: words {y35,y36}, {y37,y38}, {y3,y28,y34} on consecutive cycles → one txn_done pulse, txn_len = 3, txn_cnt = 1, err never asserted.
- Path B with body: {y1}, {y2,y3}, {y39}, {y16}, {y34} → txn_done, txn_len = 5, txn_cnt = 1.
- Injected path: {y37,y38} while in IDLE → err, err_code = 5, err_sticky = 1. A following A-path word still completes normally.
- BODY contains {y5} for MAX_BODY = 16 enabled cycles → err_code = 4, state back to IDLE, txn_cnt unchanged.
- {y1}, then {y2} alone → err_code = 2 one cycle after the {y2} sample. With en held low for 3 cycles mid-path-A, txn_len is still 3.
- rst asserted while in BODY with txn_cnt = 7 → all outputs 0 immediately, with no err or txn_done pulse.

Source files
------------

// File: rtl/bech_out_monitor_pkg.sv
// Shared types, error codes and expected-word masks for the benchmark FSM output monitor.
// Bit i of the upstream word carries y(i+1).
package bech_mon_pkg;

  localparam int unsigned Y_W   = 39;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned ERR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A1,
    ST_A2,
    ST_B1,
    ST_B2,
    ST_BODY
  } mon_state_t;

  localparam logic [ERR_W-1:0] ERR_NONE            = 3'd0;
  localparam logic [ERR_W-1:0] ERR_UNEXP_START     = 3'd1;
  localparam logic [ERR_W-1:0] ERR_SEQ_MISMATCH    = 3'd2;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL_IN_BODY = 3'd3;
  localparam logic [ERR_W-1:0] ERR_BODY_TIMEOUT    = 3'd4;
  localparam logic [ERR_W-1:0] ERR_ENTRY_NOT_IDLE  = 3'd5;

  localparam logic [Y_W-1:0] W_A_START      = (39'd1 << 34) | (39'd1 << 35);
  localparam logic [Y_W-1:0] W_A_MID        = (39'd1 << 36) | (39'd1 << 37);
  localparam logic [Y_W-1:0] W_A_END        = (39'd1 << 2) | (39'd1 << 27) | (39'd1 << 33);
  localparam logic [Y_W-1:0] W_B_START      = 39'd1 << 0;
  localparam logic [Y_W-1:0] W_B_MID        = (39'd1 << 1) | (39'd1 << 2);
  localparam logic [Y_W-1:0] W_B_BODY       = 39'd1 << 38;
  localparam logic [Y_W-1:0] W_ILLEGAL_BODY = (39'd1 << 0) | (39'd1 << 34) | (39'd1 << 35)
                                            | (39'd1 << 36) | (39'd1 << 37);
  localparam int unsigned    Y34_BIT        = 33;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : LEN_W'(v + LEN_W'(1));
  endfunction

endpackage

// File: rtl/bech_out_monitor_if.sv
// Sampled upstream word in, transaction/violation reporting out.
import bech_mon_pkg::*;

interface bech_out_monitor_if #(parameter int unsigned CNT_W = 16);
  logic              en;
  logic [Y_W-1:0]    y_vec;
  logic              txn_done;
  logic [LEN_W-1:0]  txn_len;
  logic [CNT_W-1:0]  txn_cnt;
  logic              err;
  logic [ERR_W-1:0]  err_code;
  logic              err_sticky;

  modport master (output en, y_vec,
                  input  txn_done, txn_len, txn_cnt, err, err_code, err_sticky);
  modport slave  (input  en, y_vec,
                  output txn_done, txn_len, txn_cnt, err, err_code, err_sticky);
endinterface

// File: rtl/bech_word_match.sv
// Exact-match decode of the upstream word against each expected mask.
import bech_mon_pkg::*;

module bech_word_match (
  input  logic [Y_W-1:0] i_y_vec,
  output logic           o_zero_c,
  output logic           o_a_start_c,
  output logic           o_a_mid_c,
  output logic           o_a_end_c,
  output logic           o_b_start_c,
  output logic           o_b_mid_c,
  output logic           o_b_body_c,
  output logic           o_body_illegal_c,
  output logic           o_body_end_c
);
  assign o_zero_c         = (i_y_vec == '0);
  assign o_a_start_c      = (i_y_vec == W_A_START);
  assign o_a_mid_c        = (i_y_vec == W_A_MID);
  assign o_a_end_c        = (i_y_vec == W_A_END);
  assign o_b_start_c      = (i_y_vec == W_B_START);
  assign o_b_mid_c        = (i_y_vec == W_B_MID);
  assign o_b_body_c       = (i_y_vec == W_B_BODY);
  assign o_body_illegal_c = |(i_y_vec & W_ILLEGAL_BODY);
  assign o_body_end_c     = i_y_vec[Y34_BIT];
endmodule

// File: rtl/bech_out_monitor.sv
// Runtime checker of the benchmark FSM output sequence: reports legal transactions and flags violations.
import bech_mon_pkg::*;

module bech_out_monitor #(
  parameter int unsigned MAX_BODY = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  bech_out_monitor_if.slave  mon
);
  localparam logic [LEN_W-1:0] BODY_LAST = LEN_W'(MAX_BODY - 1);

  mon_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_body_cnt;
  logic              r_txn_done;
  logic [LEN_W-1:0]  r_txn_len;
  logic [CNT_W-1:0]  r_txn_cnt;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_code;
  logic              r_err_sticky;

  logic w_zero, w_a_start, w_a_mid, w_a_end, w_b_start, w_b_mid, w_b_body;
  logic w_body_illegal, w_body_end;

  bech_word_match u_match (
    .i_y_vec          (mon.y_vec),
    .o_zero_c         (w_zero),
    .o_a_start_c      (w_a_start),
    .o_a_mid_c        (w_a_mid),
    .o_a_end_c        (w_a_end),
    .o_b_start_c      (w_b_start),
    .o_b_mid_c        (w_b_mid),
    .o_b_body_c       (w_b_body),
    .o_body_illegal_c (w_body_illegal),
    .o_body_end_c     (w_body_end)
  );

  logic [ERR_W-1:0] w_err_code;
  logic             w_fail;
  logic             w_complete;
  logic             w_advance;

  // Per-state verdict on the sampled word; the register block below only applies it.
  always_comb begin
    w_fail     = 1'b0;
    w_err_code = ERR_SEQ_MISMATCH;
    w_complete = 1'b0;
    w_advance  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_advance = w_a_start | w_b_start;
        if (w_a_mid) begin
          w_fail = 1'b1; w_err_code = ERR_ENTRY_NOT_IDLE;
        end else if (!w_zero && !w_advance) begin
          w_fail = 1'b1; w_err_code = ERR_UNEXP_START;
        end
      end
      ST_A1: begin w_advance  = w_a_mid;  w_fail = !w_a_mid;  end
      ST_A2: begin w_complete = w_a_end;  w_fail = !w_a_end;  end
      ST_B1: begin w_advance  = w_b_mid;  w_fail = !w_b_mid;  end
      ST_B2: begin w_advance  = w_b_body; w_fail = !w_b_body; end
      ST_BODY: begin
        if (w_body_illegal) begin
          w_fail = 1'b1; w_err_code = ERR_ILLEGAL_IN_BODY;
        end else if (w_body_end) begin
          w_complete = 1'b1;
        end else if (r_body_cnt == BODY_LAST) begin
          w_fail = 1'b1; w_err_code = ERR_BODY_TIMEOUT;
        end else begin
          w_advance = 1'b1;
        end
      end
      default: w_fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_body_cnt   <= '0;
      r_txn_done   <= 1'b0;
      r_txn_len    <= '0;
      r_txn_cnt    <= '0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_sticky <= 1'b0;
    end else begin
      r_txn_done <= 1'b0;
      r_err      <= 1'b0;
      if (mon.en) begin
        if (w_fail) begin
          r_err        <= 1'b1;
          r_err_code   <= w_err_code;
          r_err_sticky <= 1'b1;
          r_state      <= ST_IDLE;
          r_len        <= '0;
          r_body_cnt   <= '0;
        end else if (w_complete) begin
          r_txn_done <= 1'b1;
          r_txn_len  <= sat_inc(r_len);
          r_txn_cnt  <= CNT_W'(r_txn_cnt + CNT_W'(1));
          r_state    <= ST_IDLE;
          r_len      <= '0;
          r_body_cnt <= '0;
        end else if (w_advance) begin
          unique case (r_state)
            ST_IDLE: begin
              r_len   <= LEN_W'(1);
              r_state <= w_a_start ? ST_A1 : ST_B1;
            end
            ST_A1:   begin r_len <= sat_inc(r_len); r_state <= ST_A2;   end
            ST_B1:   begin r_len <= sat_inc(r_len); r_state <= ST_B2;   end
            ST_B2:   begin r_len <= sat_inc(r_len); r_state <= ST_BODY; end
            ST_BODY: begin
              r_len      <= sat_inc(r_len);
              r_body_cnt <= LEN_W'(r_body_cnt + LEN_W'(1));
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign mon.txn_done   = r_txn_done;
  assign mon.txn_len    = r_txn_len;
  assign mon.txn_cnt    = r_txn_cnt;
  assign mon.err        = r_err;
  assign mon.err_code   = r_err_code;
  assign mon.err_sticky = r_err_sticky;

endmodule
